sd_read_block_tx: RTL and testbench
===================================

# sd_read_block_tx

Serializes one SD-card read data block onto MISO in SPI mode: start token, BLOCK_LEN payload bytes fetched from a synchronous buffer RAM, then a CRC16-CCITT field computed on the fly. Sits in the cartridge's SPI slave path as the transmit counterpart of the MOSI-side CRC checker. It is launched by the command decoder after a read command is accepted and paces buffer reads itself.

## Interface
- BLOCK_LEN, 512, payload bytes per block (≥2); AW = $clog2(BLOCK_LEN)
- START_TOKEN, 8'hFE, token byte sent before the payload
- spi_clk  in  1  sole clock; all state updates on rising edge
- reset_n  in  1  reset, asynchronous assert, active-low
- start  in  1  one-cycle request to send a block; honoured only in IDLE
- abort  in  1  terminate transfer (stop command); priority over start
- rd_addr  out  AW  buffer byte index to be loaded next
- rd_data  in  8  buffer data; valid 1 cycle after rd_addr stable
- miso  out  1  serial data, MSB first; idle level 1
- busy  out  1  high from start acceptance until transfer ends
- done  out  1  one-cycle pulse after last CRC bit
- crc16  out  16  running CRC register (debug/verification)

## Operation
- States: IDLE, TOKEN, DATA, CRC. Bit counter 0..7, byte counter 0..BLOCK_LEN-1.
- IDLE: miso=1, busy=0. start && !abort → TOKEN, load shift reg with START_TOKEN, crc16←0, rd_addr←0.
- TOKEN: 8 bits shifted. On last bit edge: load shift reg from rd_data (byte 0), rd_addr←1, → DATA.
- DATA: each edge shifts one bit; CRC updated with the bit being driven: fb=bit^crc[15]; crc←{crc[14:0],1'b0} ^ (fb ? 16'h1021 : 0). At last bit of byte n<BLOCK_LEN-1: load rd_data, rd_addr←rd_addr+1 (wraps to 0 after final load). At last bit of final byte → CRC; crc16 then holds the final value.
- CRC: 16 bits of crc16 driven MSB first; crc16 frozen. After bit 0 → IDLE, done pulse, busy=0, miso=1.
- abort in any non-IDLE state: next edge → IDLE, miso=1, busy=0, no done; crc16 and rd_addr hold.
- start while busy ignored (no queueing).

## Timing
- Reset values: miso=1, busy=0, done=0, rd_addr=0, crc16=16'h0000, state IDLE.
- Start sampled at edge E0: miso=token bit7 and busy=1 after E0.
- Each bit held exactly one cycle; token bit7 after E0, payload bit7 of byte 0 after E8, CRC bit15 after E(8+8·BLOCK_LEN).
- Total transfer 24+8·BLOCK_LEN cycles; done high for the cycle after E(24+8·BLOCK_LEN), coincident with busy=0.
- rd_addr changes exactly at byte loads, 8 cycles ahead of use; 1-cycle RAM latency met with 7 cycles margin.
- done and start in same cycle: new transfer accepted (state is IDLE that cycle).
- reset_n low mid-transfer: immediate return to reset values, no done.

## Configuration
- SD_READ_TX_CRC_EN defined: CRC16 computed and transmitted as above.
- Undefined: CRC logic omitted; CRC phase still 16 cycles but drives constant 1s; crc16 output tied 16'hFFFF.

## Test plan
- Reset: hold reset_n low mid-DATA → miso=1, busy=0, rd_addr=0, crc16=0 immediately; no done after release.
- BLOCK_LEN=512, buffer all 8'hFF, start → stream FE, 512×FF, then 16'h7FA1; done on cycle 4120 after start edge.
- BLOCK_LEN=9, buffer "123456789" (31..39) → crc16=16'h31C3 transmitted after payload; rd_addr sequence 0,1..8,0.
- abort at payload byte 3 bit 4 → miso=1 next cycle, busy=0, no done; subsequent start sends full correct block.
- start pulsed during DATA and start+abort in IDLE → both ignored; idle start accepted back-to-back with done.
- Macro undefined, BLOCK_LEN=512 all FF → CRC field 16'hFFFF, timing identical.

Source files
------------

// File: rtl/sd_read_block_tx.sv
// SPI-mode SD read block transmitter: start token, BLOCK_LEN buffer bytes, then CRC16-CCITT, MSB first.
// Define SD_READ_TX_CRC_EN to compute and send the CRC; otherwise the CRC field is all ones.
module sd_read_block_tx #(
  parameter int          BLOCK_LEN   = 512,
  parameter logic [7:0]  START_TOKEN = 8'hFE,
  parameter int          AW          = $clog2(BLOCK_LEN)
) (
  input  logic          spi_clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          abort,
  output logic [AW-1:0] rd_addr,
  input  logic [7:0]    rd_data,
  output logic          miso,
  output logic          busy,
  output logic          done,
  output logic [15:0]   crc16
);

  typedef enum logic [1:0] {IDLE, TOKEN, DATA, CRC} state_t;

  state_t        state, state_nxt;
  logic [7:0]    shift_q;
  logic [3:0]    bit_cnt;
  logic [AW-1:0] byte_cnt;
  logic          load_byte;
  logic          crc_bit;
  logic          last8;
  logic          last_byte;
  logic          start_ok;

  assign last8     = (bit_cnt == 4'd7);
  assign last_byte = (byte_cnt == AW'(BLOCK_LEN - 1));
  assign start_ok  = start && !abort;

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    miso      = 1'b1;
    busy      = 1'b1;
    load_byte = 1'b0;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (start_ok) state_nxt = TOKEN;
      end
      TOKEN: begin
        miso = shift_q[7];
        if (last8) begin
          state_nxt = DATA;
          load_byte = 1'b1;
        end
      end
      DATA: begin
        miso = shift_q[7];
        if (last8) begin
          if (last_byte) state_nxt = CRC;
          else           load_byte = 1'b1;
        end
      end
      CRC: begin
        miso = crc_bit;
        if (bit_cnt == 4'd15) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    // Abort freezes everything and drops straight back to idle.
    if (state != IDLE && abort) begin
      state_nxt = IDLE;
      load_byte = 1'b0;
    end
  end

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q  <= '0;
      bit_cnt  <= '0;
      byte_cnt <= '0;
      rd_addr  <= '0;
      done     <= 1'b0;
    end else begin
      done <= (state == CRC) && (bit_cnt == 4'd15) && !abort;
      if (state == IDLE) begin
        if (start_ok) begin
          shift_q  <= START_TOKEN;
          bit_cnt  <= '0;
          byte_cnt <= '0;
          rd_addr  <= '0;
        end
      end else if (!abort) begin
        if (state != CRC && last8) bit_cnt <= '0;
        else                       bit_cnt <= bit_cnt + 4'd1;
        // The next address is issued a full byte ahead, hiding the RAM read latency.
        if (load_byte) begin
          shift_q <= rd_data;
          rd_addr <= (rd_addr == AW'(BLOCK_LEN - 1)) ? '0 : rd_addr + AW'(1);
        end else begin
          shift_q <= {shift_q[6:0], 1'b0};
        end
        if (state == DATA && last8) byte_cnt <= byte_cnt + AW'(1);
      end
    end
  end

`ifdef SD_READ_TX_CRC_EN
  logic [15:0] crc_q;
  logic        crc_fb;

  assign crc_fb  = shift_q[7] ^ crc_q[15];
  assign crc_bit = crc_q[~bit_cnt];
  assign crc16   = crc_q;

  always_ff @(posedge spi_clk or negedge reset_n) begin
    if (!reset_n)                               crc_q <= '0;
    else if (state == IDLE && start_ok)         crc_q <= '0;
    else if (state == DATA && !abort)
      crc_q <= {crc_q[14:0], 1'b0} ^ (crc_fb ? 16'h1021 : 16'h0000);
  end
`else
  assign crc_bit = 1'b1;
  assign crc16   = 16'hFFFF;
`endif

endmodule

// File: tb/tb_sd_read_block_tx.sv
// Self-checking bench for sd_read_block_tx: random buffer blocks compared bit-by-bit against a
// stream model built from the token, payload and CRC definition, plus abort/reset/handshake cases.
module tb_sd_read_block_tx;

  localparam int         BL     = 9;
  localparam int         AW     = $clog2(BL);
  localparam int         STREAM = 24 + 8 * BL;
  localparam logic [7:0] TOKEN  = 8'hFE;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          abort;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          miso;
  logic          busy;
  logic          done;
  logic [15:0]   crc16;

  logic [7:0] mem [0:BL-1];
  int tests = 0;
  int failures = 0;

  sd_read_block_tx #(.BLOCK_LEN(BL), .START_TOKEN(TOKEN)) dut (
    .spi_clk (clk),
    .reset_n (reset_n),
    .start   (start),
    .abort   (abort),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .miso    (miso),
    .busy    (busy),
    .done    (done),
    .crc16   (crc16)
  );

  always #5 clk = ~clk;

  // Synchronous buffer RAM with one cycle of read latency.
  always_ff @(posedge clk) rd_data <= mem[rd_addr];

  function automatic logic [15:0] crc_of(input logic [0:STREAM-1] s, input int first, input int n);
    logic [15:0] c;
    c = '0;
    for (int i = 0; i < n; i++)
      c = (c[15] ^ s[first + i]) ? ({c[14:0], 1'b0} ^ 16'h1021) : {c[14:0], 1'b0};
    return c;
  endfunction

  // Buffer address expected after edge k: k/8-based count of bytes loaded so far, modulo BL.
  function automatic int exp_addr(input int k);
    int m;
    if (k < 8) return 0;
    m = (k - 8) / 8 + 1;
    if (m > BL) m = BL;
    return m % BL;
  endfunction

  function automatic logic [15:0] exp_crc_after(input logic [0:STREAM-1] s, input int k);
    int n;
    n = k - 8;
    if (n < 0) n = 0;
    if (n > 8 * BL) n = 8 * BL;
`ifdef SD_READ_TX_CRC_EN
    return crc_of(s, 8, n);
`else
    return (n >= 0) ? 16'hFFFF : 16'h0000;
`endif
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One block: stop_at<0 runs to completion, otherwise abort (or reset) during sample stop_at.
  task automatic apply_stimulus(input string tag, input int stop_at, input bit use_reset,
                                input int pulse_at, input bit chain);
    logic [0:STREAM-1] exp_s;
    logic [0:STREAM-1] obs_s;
    logic [0:STREAM-1] mask;
    logic [15:0]       full_crc;
    int                busy_err;
    int                addr_err;
    int                late_done;
    int                last;

    exp_s = '1;
    obs_s = '0;
    mask  = '0;
    for (int i = 0; i < 8; i++) exp_s[i] = TOKEN[7 - i];
    for (int b = 0; b < BL; b++)
      for (int i = 0; i < 8; i++) exp_s[8 + 8 * b + i] = mem[b][7 - i];
    full_crc = crc_of(exp_s, 8, 8 * BL);
`ifdef SD_READ_TX_CRC_EN
    for (int i = 0; i < 16; i++) exp_s[8 + 8 * BL + i] = full_crc[15 - i];
`else
    full_crc = 16'hFFFF;
`endif

    busy_err = 0;
    addr_err = 0;
    last = (stop_at >= 0) ? stop_at : STREAM - 1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k <= last; k++) begin
      obs_s[k] = miso;
      mask[k]  = 1'b1;
      if (busy !== 1'b1 || done !== 1'b0) busy_err++;
      if (rd_addr !== AW'(exp_addr(k))) addr_err++;
      start = (k == pulse_at);
      if (k == stop_at && !use_reset) abort = 1'b1;
      if (k < last) @(negedge clk);
    end
    start = 1'b0;
    check_output({tag, "_stream"}, 128'(obs_s & mask), 128'(exp_s & mask));
    check_output({tag, "_busy_cycles"}, 128'(busy_err), 128'(0));
    check_output({tag, "_addr_cycles"}, 128'(addr_err), 128'(0));

    if (stop_at < 0) begin
      @(negedge clk);
      check_output({tag, "_done"}, 128'({done, busy, miso}), 128'(3'b101));
      check_output({tag, "_crc16"}, 128'(crc16), 128'(full_crc));
      if (chain) begin
        start = 1'b1;
      end else begin
        @(negedge clk);
        check_output({tag, "_done_one_cycle"}, 128'(done), 128'(0));
      end
    end else if (use_reset) begin
      #2 reset_n = 1'b0;
      #1;
`ifdef SD_READ_TX_CRC_EN
      check_output({tag, "_reset_vals"}, 128'({miso, busy, done, rd_addr, crc16}), 128'({3'b100, AW'(0), 16'h0000}));
`else
      check_output({tag, "_reset_vals"}, 128'({miso, busy, done, rd_addr, crc16}), 128'({3'b100, AW'(0), 16'hFFFF}));
`endif
      @(negedge clk);
      reset_n = 1'b1;
      late_done = 0;
      repeat (30) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0 || miso !== 1'b1) late_done++;
      end
      check_output({tag, "_quiet_after_reset"}, 128'(late_done), 128'(0));
    end else begin
      @(negedge clk);
      abort = 1'b0;
      check_output({tag, "_abort_outputs"}, 128'({miso, busy, done}), 128'(3'b100));
      check_output({tag, "_abort_hold"}, 128'({rd_addr, crc16}), 128'({AW'(exp_addr(stop_at)), exp_crc_after(exp_s, stop_at)}));
      late_done = 0;
      repeat (30) begin
        @(negedge clk);
        if (done !== 1'b0 || busy !== 1'b0) late_done++;
      end
      check_output({tag, "_no_done_after_abort"}, 128'(late_done), 128'(0));
    end
  endtask

  task automatic fill_random();
    for (int i = 0; i < BL; i++) mem[i] = 8'($urandom);
  endtask

  initial begin
    int k;
    reset_n = 1'b0;
    start   = 1'b0;
    abort   = 1'b0;
    for (int i = 0; i < BL; i++) mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check_output("reset_miso", 128'(miso), 128'(1));
    check_output("reset_busy_done", 128'({busy, done}), 128'(0));
    check_output("reset_rd_addr", 128'(rd_addr), 128'(0));
`ifdef SD_READ_TX_CRC_EN
    check_output("reset_crc16", 128'(crc16), 128'(16'h0000));
`else
    check_output("reset_crc16", 128'(crc16), 128'(16'hFFFF));
`endif
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < BL; i++) mem[i] = 8'h31 + 8'(i);
    apply_stimulus("ascii", -1, 1'b0, -1, 1'b0);
`ifdef SD_READ_TX_CRC_EN
    check_output("ascii_known_crc", 128'(crc16), 128'(16'h31C3));
`else
    check_output("ascii_known_crc", 128'(crc16), 128'(16'hFFFF));
`endif

    for (int i = 0; i < BL; i++) mem[i] = 8'hFF;
    apply_stimulus("all_ff", -1, 1'b0, -1, 1'b0);

    fill_random();
    apply_stimulus("abort_b3b4", 8 + 8 * 3 + 4, 1'b0, -1, 1'b0);
    fill_random();
    apply_stimulus("after_abort", -1, 1'b0, -1, 1'b0);

    fill_random();
    apply_stimulus("start_in_data", -1, 1'b0, $urandom_range(8, 8 + 8 * BL - 1), 1'b0);

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check_output("start_abort_idle", 128'({busy, miso}), 128'(2'b01));
    @(negedge clk);
    check_output("start_abort_idle_later", 128'({busy, done}), 128'(0));

    fill_random();
    apply_stimulus("chain_a", -1, 1'b0, -1, 1'b1);
    fill_random();
    apply_stimulus("chain_b", -1, 1'b0, -1, 1'b0);

    fill_random();
    k = $urandom_range(8, 8 + 8 * BL - 1);
    apply_stimulus("reset_mid_data", k, 1'b1, -1, 1'b0);
    fill_random();
    apply_stimulus("after_reset", -1, 1'b0, -1, 1'b0);

    for (int r = 0; r < 4; r++) begin
      fill_random();
      apply_stimulus("rand_abort", $urandom_range(0, STREAM - 1), 1'b0, -1, 1'b0);
      fill_random();
      apply_stimulus("rand_full", -1, 1'b0, -1, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
